uart_word_tx: RTL and testbench

//  Parametrised word-to-UART serializer; next generation of the fixed 64-bit transmit path.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 47 ++++
 rtl/uart_word_tx.sv | 203 ++++++++++++++++++++
 tb/tb_uart_word_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the word-to-UART transmit path.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
// Contents: parity mode constants, transmitter FSM state type,
//           baud divisor helper, per-byte parity helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_NEXT
  } tx_state_e;

  // Clocks per UART bit for a given system clock and baud rate.
  function automatic int unsigned clk_goal(input int unsigned f, input int unsigned bps);
    return f / bps;
  endfunction

  // Parity bit for one data byte: even = XOR of bits, odd = inverse.
  function automatic logic parity_bit(input logic [7:0] b, input int unsigned mode);
    return (^b) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts CLK_GOAL clocks per UART bit while running.
// Latency: bit_end asserts on the last clock of each bit period (combinational from the count).
// Backpressure: none; clr restarts the period so bit timing aligns to a new start bit.
// Ports: clk, rst (sync, active-high), clr (restart), run (count enable; held at 0 when low),
//        bit_end (last clock of a bit), bit_pre_end (second-to-last clock of a bit).
module uart_baud_tick #(
  parameter int unsigned CLK_GOAL = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int unsigned CW = (CLK_GOAL > 1) ? $clog2(CLK_GOAL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_GOAL - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_GOAL - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter sits at zero whenever the transmitter is idle, so every frame
  // starts from a clean phase with no drift carried over between words.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end     = run && (cnt_q == CNT_LAST);
  assign bit_pre_end = run && (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_word_tx.sv
// Word-to-UART serializer: sends a DATA_W-bit word as DATA_W/8 back-to-back UART byte frames.
// Latency: start bit drives uart_txd the cycle after acceptance; done pulses the cycle after the last stop bit.
// Backpressure: in_ready is low for the whole word; in_valid while not ready is ignored (no queueing).
// Ports: clk, rst (sync, active-high), in_data/in_valid/in_ready (word handshake),
//        busy (word in flight), done (1-cycle completion pulse), uart_txd (serial out, idle high).
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_F     = 50_000_000,
  parameter int unsigned UART_BPS  = 115200,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              uart_txd
);

  localparam int unsigned CLK_GOAL = clk_goal(CLK_F, UART_BPS);
  localparam int unsigned NBYTES   = DATA_W / 8;
  localparam int unsigned BCW      = $clog2(NBYTES + 1);

  localparam logic [BCW-1:0] BYTE_LAST = BCW'(NBYTES - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  // Elaboration-time parameter checks.
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 256) begin : g_bad_data_w
    $error("uart_word_tx: DATA_W must be a multiple of 8 in 8..256");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_word_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_word_tx: PARITY must be 0, 1 or 2");
  end
  if (CLK_GOAL < 4) begin : g_bad_goal
    $error("uart_word_tx: CLK_F/UART_BPS must be at least 4");
  end

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic              txd_q, txd_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              bit_end;
  logic              bit_pre_end;
  logic [7:0]        cur_byte;

  assign accept = in_valid && ready_q;

  // The byte on the wire always sits at the leading end of the shift register;
  // the register shifts by one byte toward that end as each frame finishes.
  assign cur_byte = (LSB_FIRST != 0) ? sh_q[7:0] : sh_q[DATA_W-1 -: 8];

  uart_baud_tick #(
    .CLK_GOAL (CLK_GOAL)
  ) u_baud_tick (
    .clk         (clk),
    .rst         (rst),
    .clr         (accept),
    .run         (state_q != ST_IDLE),
    .bit_end     (bit_end),
    .bit_pre_end (bit_pre_end)
  );

  // Next-state and registered-output logic. uart_txd is computed for the
  // state being entered so the pin changes exactly on the bit boundary.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    byte_cnt_d = byte_cnt_q;
    txd_d      = txd_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          sh_d       = in_data;
          byte_cnt_d = '0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          state_d    = ST_START;
          txd_d      = 1'b0;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          txd_d     = cur_byte[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
              txd_d   = parity_bit(cur_byte, PARITY);
            end else begin
              state_d    = ST_STOP;
              stop_idx_d = 1'b0;
              txd_d      = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
          txd_d      = 1'b1;
        end
      end

      // The final clock of the last stop bit is spent in NEXT, where the
      // byte-remaining decision is made; this keeps the gap to the next
      // start bit at zero cycles.
      ST_STOP: begin
        txd_d = 1'b1;
        if ((stop_idx_q == STOP_LAST) && bit_pre_end) begin
          state_d = ST_NEXT;
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end

      ST_NEXT: begin
        txd_d = 1'b1;
        if (bit_end) begin
          if (byte_cnt_q == BYTE_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
            sh_d       = (LSB_FIRST != 0) ? (sh_q >> 8) : (sh_q << 8);
            state_d    = ST_START;
            txd_d      = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      byte_cnt_q <= '0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      byte_cnt_q <= byte_cnt_d;
      txd_q      <= txd_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: six configurations run side by side against a
// queue-based waveform model, plus literal expectations on the captured pin.
module tb_uart_word_tx;

  localparam int NI = 6;
  localparam int G  = 10;
  localparam int HN = 4096;

  function automatic int cfg_dw(input int i);
    case (i)
      0, 3, 4: return 8;
      1, 2:    return 64;
      default: return 32;
    endcase
  endfunction
  function automatic int cfg_lsb(input int i);
    return (i == 2) ? 0 : 1;
  endfunction
  function automatic int cfg_par(input int i);
    return (i == 3) ? 1 : ((i == 4) ? 2 : 0);
  endfunction
  function automatic int cfg_stop(input int i);
    return (i == 4) ? 2 : 1;
  endfunction

  logic              clk;
  logic [NI-1:0]     rst_v;
  logic [NI-1:0]     vld_v;
  logic [255:0]      dat_v [NI];
  logic [NI-1:0]     txd_w, busy_w, rdy_w, done_w;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW = cfg_dw(g);
    uart_word_tx #(
      .CLK_F     (1000),
      .UART_BPS  (100),
      .DATA_W    (DW),
      .LSB_FIRST (cfg_lsb(g)),
      .PARITY    (cfg_par(g)),
      .STOP_BITS (cfg_stop(g))
    ) u_dut (
      .clk      (clk),
      .rst      (rst_v[g]),
      .in_data  (dat_v[g][DW-1:0]),
      .in_valid (vld_v[g]),
      .in_ready (rdy_w[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .uart_txd (txd_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: expected outputs for the cycle being observed.
  logic [NI-1:0] m_txd  = '1;
  logic [NI-1:0] m_busy = '0;
  logic [NI-1:0] m_rdy  = '1;
  logic [NI-1:0] m_done = '0;
  bit            wf_q [NI][$];
  int            acc_q [NI][$];
  logic          txd_h  [NI][HN];
  logic          done_h [NI][HN];

  task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", nm, i, cyc, got, exp);
    end
  endtask

  task automatic push_bit(input int i, input bit v);
    for (int k = 0; k < G; k++) wf_q[i].push_back(v);
  endtask

  // Expected pin waveform of a whole word, one entry per clock.
  task automatic push_word(input int i, input logic [255:0] d);
    int nb;
    nb = cfg_dw(i) / 8;
    for (int b = 0; b < nb; b++) begin
      logic [7:0] by;
      int idx;
      idx = (cfg_lsb(i) != 0) ? b : (nb - 1 - b);
      by  = d[idx*8 +: 8];
      push_bit(i, 1'b0);
      for (int k = 0; k < 8; k++) push_bit(i, by[k]);
      if (cfg_par(i) != 0) push_bit(i, (^by) ^ (cfg_par(i) == 2));
      for (int s = 0; s < cfg_stop(i); s++) push_bit(i, 1'b1);
    end
  endtask

  // Compare, record, then advance the model across the coming posedge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk("txd",   i, 64'(txd_w[i]),  64'(m_txd[i]));
      chk("busy",  i, 64'(busy_w[i]), 64'(m_busy[i]));
      chk("ready", i, 64'(rdy_w[i]),  64'(m_rdy[i]));
      chk("done",  i, 64'(done_w[i]), 64'(m_done[i]));
      if (cyc < HN) begin
        txd_h[i][cyc]  = txd_w[i];
        done_h[i][cyc] = done_w[i];
      end
      if (rst_v[i]) begin
        wf_q[i].delete();
        m_txd[i] = 1'b1; m_busy[i] = 1'b0; m_rdy[i] = 1'b1; m_done[i] = 1'b0;
      end else if (m_rdy[i] && vld_v[i]) begin
        push_word(i, dat_v[i]);
        m_txd[i] = wf_q[i].pop_front();
        m_busy[i] = 1'b1; m_rdy[i] = 1'b0; m_done[i] = 1'b0;
        acc_q[i].push_back(cyc + 1);
      end else if (wf_q[i].size() > 0) begin
        m_txd[i] = wf_q[i].pop_front();
        m_done[i] = 1'b0;
      end else if (m_busy[i]) begin
        m_txd[i] = 1'b1; m_busy[i] = 1'b0; m_rdy[i] = 1'b1; m_done[i] = 1'b1;
      end else begin
        m_done[i] = 1'b0;
      end
    end
    cyc++;
  end

  function automatic int acc(input int i, input int k);
    return (k < acc_q[i].size()) ? acc_q[i][k] : 0;
  endfunction
  function automatic logic th(input int i, input int c);
    return (c >= 0 && c < HN) ? txd_h[i][c] : 1'bx;
  endfunction
  function automatic logic dh(input int i, input int c);
    return (c >= 0 && c < HN) ? done_h[i][c] : 1'bx;
  endfunction
  // Decode the byte of the frame whose start bit begins at cycle base.
  function automatic logic [7:0] dec(input int i, input int base);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = th(i, base + G + G*k + G/2);
    return b;
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0]  frm_a5;
    logic [63:0] exp_lsb, exp_msb;
    logic [31:0] exp5;
    int          a, cnt;

    rst_v = '1;
    vld_v = '0;
    for (int i = 0; i < NI; i++) dat_v[i] = '0;
    tick(3);
    rst_v = '0;
    tick(2);

    dat_v[0] = 256'h A5;
    dat_v[1] = 256'h 0123_4567_89AB_CDEF;
    dat_v[2] = 256'h 0123_4567_89AB_CDEF;
    dat_v[3] = 256'h 07;
    dat_v[4] = 256'h 07;
    dat_v[5] = 256'h DEAD_BEEF;
    vld_v = 6'b111111;
    tick(1);
    vld_v = '0;

    // Abandon the 32-bit word partway through, then send a fresh one.
    tick(34);
    rst_v[5] = 1'b1;
    tick(1);
    rst_v[5] = 1'b0;
    tick(5);
    dat_v[5] = 256'h 1234_5678;
    vld_v[5] = 1'b1;
    tick(1);
    vld_v[5] = 1'b0;
    tick(79);

    // in_valid held high with data changing every cycle on instance 0.
    for (int j = 0; j < 350; j++) begin
      vld_v[0] = 1'b1;
      dat_v[0] = 256'((j * 29 + 7) & 8'hFF);
      if (j == 10) begin
        dat_v[3] = '0; dat_v[4] = '0;
        vld_v[3] = 1'b1; vld_v[4] = 1'b1;
      end else begin
        vld_v[3] = 1'b0; vld_v[4] = 1'b0;
      end
      tick(1);
    end
    vld_v = '0;
    tick(900);

    // Literal expectations.
    frm_a5 = 10'b11_0100_1010;  // bit0 first: 0,1,0,1,0,0,1,0,1,1
    a = acc(0, 0);
    for (int k = 0; k < 10; k++) chk("a5_bit", 0, 64'(th(0, a + G*k + G/2)), 64'(frm_a5[k]));
    chk("a5_done_101", 0, 64'(dh(0, a + 100)), 64'd1);
    chk("a5_no_early_done", 0, 64'(dh(0, a + 99)), 64'd0);
    chk("b2b_words", 0, 64'(acc_q[0].size()), 64'd5);
    chk("b2b_gap", 0, 64'(acc(0, 2) - acc(0, 1)), 64'd101);
    chk("b2b_start", 0, 64'(th(0, acc(0, 2))), 64'd0);
    chk("b2b_idle_done", 0, 64'(th(0, acc(0, 2) - 1)), 64'd1);

    exp_lsb = 64'h EFCD_AB89_6745_2301;
    exp_msb = 64'h 0123_4567_89AB_CDEF;
    for (int b = 0; b < 8; b++) begin
      chk("lsb_byte", 1, 64'(dec(1, acc(1, 0) + 100*b)), 64'(exp_lsb[63-8*b -: 8]));
      chk("msb_byte", 2, 64'(dec(2, acc(2, 0) + 100*b)), 64'(exp_msb[63-8*b -: 8]));
    end
    for (int b = 0; b < 7; b++) begin
      chk("gap_stop", 2, 64'(th(2, acc(2, 0) + 100*(b+1) - 1)), 64'd1);
      chk("gap_start", 2, 64'(th(2, acc(2, 0) + 100*(b+1))), 64'd0);
    end
    chk("w64_done_800", 1, 64'(dh(1, acc(1, 0) + 800)), 64'd1);

    chk("even_07", 3, 64'(th(3, acc(3, 0) + 95)), 64'd1);
    chk("even_00", 3, 64'(th(3, acc(3, 1) + 95)), 64'd0);
    chk("odd_07", 4, 64'(th(4, acc(4, 0) + 95)), 64'd0);
    chk("odd_00", 4, 64'(th(4, acc(4, 1) + 95)), 64'd1);
    cnt = 0;
    for (int c = 0; c < 20; c++) if (th(4, acc(4, 0) + 100 + c) === 1'b1) cnt++;
    chk("stop2_high20", 4, 64'(cnt), 64'd20);
    chk("stop2_done_120", 4, 64'(dh(4, acc(4, 0) + 120)), 64'd1);

    exp5 = 32'h 7856_3412;
    for (int b = 0; b < 4; b++) chk("after_rst_byte", 5, 64'(dec(5, acc(5, 1) + 100*b)), 64'(exp5[31-8*b -: 8]));
    chk("after_rst_done", 5, 64'(dh(5, acc(5, 1) + 400)), 64'd1);
    cnt = 0;
    for (int c = 0; c < HN; c++) if (done_h[5][c] === 1'b1) cnt++;
    chk("rst_no_done", 5, 64'(cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
